// File: rtl/life_pkg.sv
// Shared types and helpers for the tiled Game-of-Life grid.
// Optional build macro: LIFE_WRAP_EN (toroidal edges), consumed by life_grid_tiled.
package life_pkg;

    localparam int TILE_SIDE = 4;
    localparam int TILE_BITS = 16;

    typedef enum logic {
        IDLE  = 1'b0,
        COUNT = 1'b1
    } state_t;

    // Flat bit index of local cell (lx, ly) inside tile (tx, ty); tiles are column-major
    function automatic int cell_index(input int tx, input int ty, input int lx,
                                      input int ly, input int tiles_y);
        return (tx * tiles_y + ty) * TILE_BITS + TILE_SIDE * lx + ly;
    endfunction

    // Live-cell count of one tile word
    function automatic logic [4:0] popcount16(input logic [15:0] word);
        logic [4:0] cnt;
        cnt = '0;
        for (int i = 0; i < 16; i++) cnt = cnt + {4'b0, word[i]};
        return cnt;
    endfunction

endpackage

// File: rtl/life_cell_next.sv
// Single-cell B3/S23 successor: eight neighbour bits and the current bit in, next bit out.
module life_cell_next (
    input  logic [7:0] nbrs,
    input  logic       cur,
    output logic       nxt
);

    logic [3:0] cnt;

    // Count live neighbours, then apply birth-on-3 / survive-on-2-or-3
    always_comb begin
        cnt = '0;
        for (int i = 0; i < 8; i++) cnt = cnt + {3'b0, nbrs[i]};
        nxt = (cnt == 4'd3) || (cur && (cnt == 4'd2));
    end

endmodule

// File: rtl/life_grid_tiled.sv
// Tiled Game-of-Life grid with step handshake, generation counter, sequential
// population count and still-life / period-2 detection.
// Optional build macro: LIFE_WRAP_EN -- when defined the grid edges are toroidal,
// otherwise every out-of-grid neighbour reads as dead.
module life_grid_tiled
    import life_pkg::*;
#(
    parameter  int TILES_X = 2,
    parameter  int TILES_Y = 2,
    parameter  int GEN_W   = 16,
    localparam int NT      = TILES_X * TILES_Y,
    localparam int SEL_W   = (NT > 1) ? $clog2(NT) : 1,
    localparam int POP_W   = $clog2(16 * NT + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [15:0]      vali,
    input  logic [SEL_W-1:0] vali_selector,
    input  logic             write_enb,
    input  logic [SEL_W-1:0] valo_selector,
    output logic [15:0]      valo,
    output logic [15:0]      valo_prev,
    input  logic             step,
    input  logic             clear,
    output logic             busy,
    output logic             done,
    output logic [GEN_W-1:0] generation,
    output logic [POP_W-1:0] population,
    output logic             pop_valid,
    output logic             stable,
    output logic             oscillating
);

    localparam int W  = TILE_SIDE * TILES_X;
    localparam int H  = TILE_SIDE * TILES_Y;
    localparam int NB = NT * TILE_BITS;

    logic [NB-1:0]    cells;
    logic [NB-1:0]    prev;
    logic [NB-1:0]    next_cells;
    state_t           state;
    state_t           state_nxt;
    logic [SEL_W-1:0] k;
    logic [POP_W-1:0] acc;
    logic [POP_W-1:0] acc_sum;
    logic [15:0]      count_tile;
    logic             do_clear;
    logic             do_step;
    logic             do_write;
    logic             count_last;

    // Neighbourhood wiring is resolved at elaboration; each cell gets its own rule instance
    for (genvar gx = 0; gx < W; gx++) begin : g_x
        for (genvar gy = 0; gy < H; gy++) begin : g_y
            localparam int IDX = cell_index(gx / 4, gy / 4, gx % 4, gy % 4, TILES_Y);
            logic [7:0] nbrs;
            for (genvar d = 0; d < 9; d++) begin : g_nb
                if (d != 4) begin : g_use
                    localparam int RX   = gx + d / 3 - 1;
                    localparam int RY   = gy + d % 3 - 1;
                    localparam int SLOT = (d < 4) ? d : d - 1;
`ifdef LIFE_WRAP_EN
                    localparam int NX = (RX + W) % W;
                    localparam int NY = (RY + H) % H;
                    assign nbrs[SLOT] = cells[cell_index(NX / 4, NY / 4, NX % 4, NY % 4, TILES_Y)];
`else
                    if (RX >= 0 && RX < W && RY >= 0 && RY < H) begin : g_in
                        assign nbrs[SLOT] = cells[cell_index(RX / 4, RY / 4, RX % 4, RY % 4, TILES_Y)];
                    end else begin : g_out
                        assign nbrs[SLOT] = 1'b0;
                    end
`endif
                end
            end
            life_cell_next u_cell (
                .nbrs (nbrs),
                .cur  (cells[IDX]),
                .nxt  (next_cells[IDX])
            );
        end
    end

    // Read mux for the renderer; unmatched selectors read as zero
    always_comb begin
        valo      = '0;
        valo_prev = '0;
        for (int t = 0; t < NT; t++) begin
            if (valo_selector == SEL_W'(t)) begin
                valo      = cells[t*16 +: 16];
                valo_prev = prev[t*16 +: 16];
            end
        end
    end

    // Tile being summed this COUNT cycle and the running total including it
    always_comb begin
        count_tile = '0;
        for (int t = 0; t < NT; t++) begin
            if (k == SEL_W'(t)) count_tile = cells[t*16 +: 16];
        end
        acc_sum = acc + POP_W'(popcount16(count_tile));
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    // FSM next state: a step leaves IDLE unless clear wins; COUNT ends after the last tile
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (!clear && step) state_nxt = COUNT;
            COUNT:   if (k == SEL_W'(NT - 1)) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // FSM outputs: command strobes (clear > step > write, IDLE only) and busy
    always_comb begin
        busy       = (state == COUNT);
        do_clear   = (state == IDLE) && clear;
        do_step    = (state == IDLE) && !clear && step;
        do_write   = (state == IDLE) && !clear && !step && write_enb;
        count_last = (state == COUNT) && (k == SEL_W'(NT - 1));
    end

    // Grid state, generation bookkeeping and the population accumulator
    always_ff @(posedge clk) begin
        if (!reset) begin
            cells       <= '0;
            prev        <= '0;
            generation  <= '0;
            population  <= '0;
            pop_valid   <= 1'b1;
            stable      <= 1'b0;
            oscillating <= 1'b0;
            done        <= 1'b0;
            k           <= '0;
            acc         <= '0;
        end else begin
            done <= count_last;
            if (do_clear) begin
                cells       <= '0;
                prev        <= '0;
                generation  <= '0;
                population  <= '0;
                pop_valid   <= 1'b1;
                stable      <= 1'b0;
                oscillating <= 1'b0;
            end else if (do_step) begin
                prev        <= cells;
                cells       <= next_cells;
                generation  <= generation + 1'b1;
                stable      <= (next_cells == cells);
                oscillating <= (next_cells == prev);
                acc         <= '0;
                k           <= '0;
                pop_valid   <= 1'b0;
            end else if (do_write) begin
                for (int t = 0; t < NT; t++) begin
                    if (vali_selector == SEL_W'(t)) cells[t*16 +: 16] <= vali;
                end
                pop_valid <= 1'b0;
            end
            if (busy) begin
                acc <= acc_sum;
                k   <= k + 1'b1;
                if (count_last) begin
                    population <= acc_sum;
                    pop_valid  <= 1'b1;
                end
            end
        end
    end

endmodule

// File: doc/life_grid_tiled.md
Name: life_grid_tiled

Overview:
- Parametrised Game-of-Life grid built from TILES_X × TILES_Y tiles of 4×4 cells; a successor to the fixed 2×2-tile array.
- Adds:
  - a step handshake (busy/done);
  - a generation counter;
  - a sequential population count;
  - still-life and period-2 detection.
- Sits between the controller, which writes and steps the grid, and the VGA renderer, which reads tiles through valo/valo_prev.

Parameters:
- TILES_X, 2, tiles across (east); ≥1
- TILES_Y, 2, tiles down (south); ≥1
- GEN_W, 16, generation counter width
- Derived localparams, not overridable:
  - NT = TILES_X*TILES_Y
  - SEL_W = max(1, clog2(NT))
  - POP_W = clog2(16*NT + 1)

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-low reset
- vali  in  16  tile word to write
- vali_selector  in  SEL_W  tile index for the write
- write_enb  in  1  write vali into the selected tile
- valo_selector  in  SEL_W  tile index for the read
- valo  out  16  current state of the selected tile (combinational)
- valo_prev  out  16  previous-generation state of the selected tile (combinational)
- step  in  1  request one generation
- clear  in  1  kill all cells
- busy  out  1  step in progress
- done  out  1  one-cycle pulse when a step completes
- generation  out  GEN_W  completed generations since reset or clear
- population  out  POP_W  live-cell count
- pop_valid  out  1  population matches the current grid
- stable  out  1  last step produced no change
- oscillating  out  1  last step's result equals the pre-step previous generation

Behaviour:
- Geometry:
  - Tile index = tx*TILES_Y + ty, column-major; tile 0 is the NW tile.
  - Bit within a tile word = 4*lx + ly, where lx is the column (0 = west) and ly is the row (0 = north).
  - Global cell (x, y): x = 4*tx + lx, y = 4*ty + ly.
- Rule: B3/S23 over 8 neighbours. Out-of-grid neighbours are 0 unless LIFE_WRAP_EN is defined.
- Reset (reset = 0 at a clk edge):
  - All cells and prev cells cleared.
  - generation = 0, population = 0, pop_valid = 1.
  - busy, done, stable, oscillating = 0.
  - FSM goes to IDLE. This applies from any state, including mid-COUNT.
- FSM states: IDLE, COUNT.
- IDLE, priority clear > step > write:
  - clear: cells = 0, prev = 0, generation = 0, population = 0, pop_valid = 1, stable = 0, oscillating = 0.
  - step (cycle T): at edge T+1, the update commits:
    - prev <= cur; cur <= next.
    - generation <= generation + 1, wrapping at 2^GEN_W.
    - stable <= (next == cur); oscillating <= (next == prev).
    - count accumulator <= 0, k <= 0, pop_valid <= 0, busy <= 1; go to COUNT.
  - write_enb with no clear or step: tile[vali_selector] <= vali; prev is unchanged; pop_valid <= 0.
  - A selector ≥ NT is ignored for writes and reads valo = valo_prev = 0.
- COUNT:
  - Each cycle, acc += popcount(tile k); k++.
  - After the cycle that adds tile NT-1: population <= final sum, pop_valid <= 1, done = 1 for exactly that cycle, busy <= 0, go to IDLE.
  - done is asserted NT cycles after the commit edge. A new step can be accepted on the cycle after done.
  - step, write_enb and clear are ignored while busy; cells do not change.
- valo/valo_prev are a pure combinational mux and are valid in every state.

Optional Feature:
- Macro: LIFE_WRAP_EN.
- Defined: toroidal edges.
  - x = -1 maps to 4*TILES_X-1; y = -1 maps to 4*TILES_Y-1, and vice versa.
  - Corners wrap diagonally.
- Undefined: all out-of-grid neighbours are dead.
- Port list is identical in both builds.

Decomposition:
- Package life_pkg:
  - TILE_SIDE = 4, TILE_BITS = 16;
  - FSM state enum;
  - cell-index function (tx, ty, lx, ly) → flat bit index.
- Sub-module life_cell_next: 8 neighbour bits plus the current bit in, next bit out. Instantiated per cell in a generate loop.
- The 16-bit popcount is a function in life_pkg.

Test Plan:
- Reset, then blinker: tile0 = 0x4000, tile2 = 0x0044. Step → tile0 = 0x0000, tile2 = 0x000E, population = 3, oscillating = 0. Step again → original pattern restored, oscillating = 1, generation = 2.
- Block: tile0 = 0x0660, step → tile0 unchanged, stable = 1, population = 4. done is asserted exactly 4 cycles after the commit edge (NT = 4).
- West-edge blinker: tile0 = 0x0008, tile1 = 0x0003, step.
  - No wrap → tile1 = 0x0011, population = 2.
  - LIFE_WRAP_EN → additionally tile3 = 0x1000, population = 3.
- Glider in tile 0 stepped 8 times crosses into tiles 2, 1 and 3. Every generation matches the reference model; population = 5 at each done.
- write_enb and step asserted during COUNT → no cell change, no extra generation; pop_valid is 0 after an IDLE write; clear takes priority over a simultaneous step.
- Reset asserted mid-COUNT → next cycle all outputs at reset values; a subsequent step on the empty grid gives population = 0, stable = 1.
